// File: rtl/indications_compositor_pkg.sv
// indications_pkg: shared RGB332 types, fixed colours and blinker state encoding for the HUD compositor
package indications_pkg;
  localparam int RGB_W = 8;
  typedef logic [RGB_W-1:0] rgb_t;
  localparam rgb_t HIGHLIGHT_RGB = 8'hE0;
  localparam rgb_t TRANSPARENT_RGB = 8'h00;
  typedef enum logic [1:0] {BLINK_ST_IDLE, BLINK_ST_ON, BLINK_ST_OFF} blink_state_t;
endpackage

// File: rtl/indications_compositor_if.sv
// indications_compositor_if: drawer-side layer inputs and composited HUD outputs
interface indications_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int VAL_W = 4
);
  import indications_pkg::*;
  logic startOfFrame;
  logic [NUM_LAYERS-1:0] layerDraw;
  logic [NUM_LAYERS*RGB_W-1:0] layerRGB;
  logic [NUM_LAYERS*VAL_W-1:0] layerValue;
  logic drawIndications;
  rgb_t RGBIndications;
  logic [NUM_LAYERS-1:0] blinkActive;
  modport master (
    output startOfFrame, layerDraw, layerRGB, layerValue,
    input drawIndications, RGBIndications, blinkActive
  );
  modport slave (
    input startOfFrame, layerDraw, layerRGB, layerValue,
    output drawIndications, RGBIndications, blinkActive
  );
endinterface

// File: rtl/indications_compositor_blinker.sv
// indication_blinker: per-layer value latch, change detect and frame-paced ON/OFF blink FSM
module indication_blinker
  import indications_pkg::*;
#(
  parameter int VAL_W = 4,
  parameter int BLINK_FRAMES = 32,
  parameter int TOGGLE_FRAMES = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic sof,
  input  logic armed,
  input  logic [VAL_W-1:0] value,
  output logic visible,
  output logic highlight,
  output logic blink_active
);
  blink_state_t state;
  logic [VAL_W-1:0] last_value;
  logic [7:0] frame_cnt;
  logic [7:0] toggle_cnt;
  logic trigger;
  logic toggle_last;
  assign trigger = armed && (value != last_value);
  assign toggle_last = toggle_cnt == 8'(TOGGLE_FRAMES - 1);
  assign blink_active = state != BLINK_ST_IDLE;
`ifdef INDICATIONS_HIGHLIGHT_EN
  assign visible = 1'b1;
  assign highlight = state == BLINK_ST_OFF;
`else
  assign visible = state != BLINK_ST_OFF;
  assign highlight = 1'b0;
`endif
  // all state moves only on startOfFrame so a frame is never torn
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= BLINK_ST_IDLE;
      frame_cnt <= '0;
      toggle_cnt <= '0;
      last_value <= '0;
    end else if (sof) begin
      last_value <= value;
      if (trigger) begin
        state <= BLINK_ST_ON;
        frame_cnt <= '0;
        toggle_cnt <= '0;
      end else if (state != BLINK_ST_IDLE) begin
        if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
          state <= BLINK_ST_IDLE;
          frame_cnt <= '0;
          toggle_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
          toggle_cnt <= toggle_last ? 8'd0 : toggle_cnt + 8'd1;
          if (toggle_last) state <= (state == BLINK_ST_ON) ? BLINK_ST_OFF : BLINK_ST_ON;
        end
      end
    end
  end
endmodule

// File: rtl/indications_compositor.sv
// indications_compositor: fixed-priority HUD layer mux (layer 0 wins) with per-layer change blinking.
// Define INDICATIONS_HIGHLIGHT_EN to recolor OFF-phase layers with HIGHLIGHT_RGB instead of hiding them.
module indications_compositor
  import indications_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int VAL_W = 4,
  parameter int BLINK_FRAMES = 32,
  parameter int TOGGLE_FRAMES = 4
) (
  input logic clk,
  input logic resetN,
  indications_compositor_if.slave bus
);
  logic armed;
  logic [NUM_LAYERS-1:0] visible;
  logic [NUM_LAYERS-1:0] highlight;
  logic [NUM_LAYERS-1:0] active;
  logic draw_n;
  rgb_t rgb_n;
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    indication_blinker #(
      .VAL_W(VAL_W),
      .BLINK_FRAMES(BLINK_FRAMES),
      .TOGGLE_FRAMES(TOGGLE_FRAMES)
    ) u_blinker (
      .clk(clk),
      .resetN(resetN),
      .sof(bus.startOfFrame),
      .armed(armed),
      .value(bus.layerValue[VAL_W*i +: VAL_W]),
      .visible(visible[i]),
      .highlight(highlight[i]),
      .blink_active(active[i])
    );
  end
  assign bus.blinkActive = active;
  // descending scan so the lowest eligible index is the last writer
  always_comb begin
    draw_n = 1'b0;
    rgb_n = TRANSPARENT_RGB;
    for (int j = NUM_LAYERS - 1; j >= 0; j--) begin
      if (bus.layerDraw[j] && visible[j]) begin
        draw_n = 1'b1;
        rgb_n = highlight[j] ? HIGHLIGHT_RGB : bus.layerRGB[RGB_W*j +: RGB_W];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      armed <= 1'b0;
      bus.drawIndications <= 1'b0;
      bus.RGBIndications <= TRANSPARENT_RGB;
    end else begin
      armed <= armed | bus.startOfFrame;
      bus.drawIndications <= draw_n;
      bus.RGBIndications <= rgb_n;
    end
  end
endmodule

// File: tb/tb_indications_compositor.sv
// tb_indications_compositor: vector table, directed blink sequences and random traffic vs a frame-count model
module tb_indications_compositor;
  import indications_pkg::*;
  localparam int NL = 4;
  localparam int VW = 4;
  localparam int BF = 32;
  localparam int TF = 4;
`ifdef INDICATIONS_HIGHLIGHT_EN
  localparam bit HL = 1'b1;
`else
  localparam bit HL = 1'b0;
`endif
  localparam logic [8*NL-1:0] RGB = 32'h03E3FC1C;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;
  indications_compositor_if #(.NUM_LAYERS(NL), .VAL_W(VW)) bus ();
  indications_compositor #(
    .NUM_LAYERS(NL), .VAL_W(VW), .BLINK_FRAMES(BF), .TOGGLE_FRAMES(TF)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus.slave)
  );
  typedef struct {
    logic rn;
    logic sof;
    logic [NL-1:0] d;
    logic [8*NL-1:0] r;
    logic [VW*NL-1:0] v;
    logic e_d;
    logic [7:0] e_rgb;
    logic [NL-1:0] e_b;
  } vec_t;
  vec_t tbl[11];
  int n_vec = 0;
  int n_err = 0;
  int frame;
  int start_f[NL];
  logic [VW-1:0] last_v[NL];
  bit armed;
  logic exp_draw;
  logic [7:0] exp_rgb;
  int cnt;
  int cnt2;
  logic [VW*NL-1:0] cur_v;

  // layer is blinking for BF frames counted from the frame of its last change
  function automatic bit m_act(int i);
    return start_f[i] >= 0 && (frame - start_f[i]) < BF;
  endfunction
  function automatic bit m_off(int i);
    return m_act(i) && (((frame - start_f[i]) / TF) % 2 == 1);
  endfunction
  function automatic logic [NL-1:0] m_blink();
    logic [NL-1:0] b;
    for (int i = 0; i < NL; i++) b[i] = m_act(i);
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input string nm, input logic rn, input logic s, input logic [NL-1:0] d,
                      input logic [8*NL-1:0] r, input logic [VW*NL-1:0] v);
    resetN = rn;
    bus.startOfFrame = s;
    bus.layerDraw = d;
    bus.layerRGB = r;
    bus.layerValue = v;
    exp_draw = 1'b0;
    exp_rgb = 8'h00;
    if (rn)
      for (int i = NL - 1; i >= 0; i--)
        if (d[i] && (!m_off(i) || HL)) begin
          exp_draw = 1'b1;
          exp_rgb = m_off(i) ? 8'hE0 : r[8*i +: 8];
        end
    if (!rn) begin
      frame = 0;
      armed = 1'b0;
      for (int i = 0; i < NL; i++) begin
        start_f[i] = -1;
        last_v[i] = '0;
      end
    end else if (s) begin
      frame++;
      for (int i = 0; i < NL; i++) begin
        if (armed && v[VW*i +: VW] != last_v[i]) start_f[i] = frame;
        last_v[i] = v[VW*i +: VW];
      end
      armed = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({nm, ".draw"}, 32'(bus.drawIndications), 32'(exp_draw));
    chk({nm, ".rgb"}, 32'(bus.RGBIndications), 32'(exp_rgb));
    chk({nm, ".blink"}, 32'(bus.blinkActive), 32'(m_blink()));
  endtask

  task automatic frame_step(input string nm, input logic [VW*NL-1:0] v, input logic [NL-1:0] d);
    step(nm, 1'b1, 1'b1, d, RGB, v);
    step(nm, 1'b1, 1'b0, d, RGB, v);
    step(nm, 1'b1, 1'b0, d, RGB, v);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 4'hF, RGB, 16'h0000, 1'b1, 8'h1C, 4'h0};
    tbl[1]  = '{1'b0, 1'b0, 4'hF, RGB, 16'h0000, 1'b0, 8'h00, 4'h0};
    tbl[2]  = '{1'b1, 1'b0, 4'h5, RGB, 16'h0000, 1'b1, 8'h1C, 4'h0};
    tbl[3]  = '{1'b1, 1'b0, 4'h4, RGB, 16'h0000, 1'b1, 8'hE3, 4'h0};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, RGB, 16'h0000, 1'b0, 8'h00, 4'h0};
    tbl[5]  = '{1'b1, 1'b0, 4'h8, RGB, 16'h0000, 1'b1, 8'h03, 4'h0};
    tbl[6]  = '{1'b1, 1'b0, 4'h6, RGB, 16'h0000, 1'b1, 8'hFC, 4'h0};
    tbl[7]  = '{1'b1, 1'b1, 4'h1, RGB, 16'h0003, 1'b1, 8'h1C, 4'h0};
    tbl[8]  = '{1'b1, 1'b1, 4'h0, RGB, 16'h0002, 1'b0, 8'h00, 4'h1};
    tbl[9]  = '{1'b1, 1'b0, 4'h3, RGB, 16'h0002, 1'b1, 8'h1C, 4'h1};
    tbl[10] = '{1'b0, 1'b0, 4'hF, RGB, 16'h0002, 1'b0, 8'h00, 4'h0};
    bus.startOfFrame = 1'b0;
    bus.layerDraw = '0;
    bus.layerRGB = '0;
    bus.layerValue = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.draw", 32'(bus.drawIndications), 32'd0);
    chk("reset.rgb", 32'(bus.RGBIndications), 32'd0);
    chk("reset.blink", 32'(bus.blinkActive), 32'd0);
    for (int k = 0; k < 11; k++) begin
      resetN = tbl[k].rn;
      bus.startOfFrame = tbl[k].sof;
      bus.layerDraw = tbl[k].d;
      bus.layerRGB = tbl[k].r;
      bus.layerValue = tbl[k].v;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.draw", k), 32'(bus.drawIndications), 32'(tbl[k].e_d));
      chk($sformatf("tbl%0d.rgb", k), 32'(bus.RGBIndications), 32'(tbl[k].e_rgb));
      chk($sformatf("tbl%0d.blink", k), 32'(bus.blinkActive), 32'(tbl[k].e_b));
    end
    // single change: blink window length and phase pixels
    step("t3rst", 1'b0, 1'b0, 4'h0, RGB, 16'h0);
    frame_step("t3arm", 16'h0003, 4'h3);
    chk("t3_no_blink_on_arm", 32'(bus.blinkActive), 32'd0);
    cnt = 0;
    for (int f = 0; f < 40; f++) begin
      frame_step("t3", 16'h0002, 4'h3);
      if (bus.blinkActive[0]) cnt++;
      if (f == 4) chk("t3_off_pixel", 32'(bus.RGBIndications), HL ? 32'hE0 : 32'hFC);
      if (f == 8) chk("t3_on_pixel", 32'(bus.RGBIndications), 32'h1C);
    end
    chk("t3_blink_frames", cnt, BF);
    // retrigger at frame 20 of a blink
    step("t5rst", 1'b0, 1'b0, 4'h0, RGB, 16'h0);
    frame_step("t5arm", 16'h0003, 4'h1);
    cnt = 0;
    cnt2 = 0;
    for (int f = 0; f < 60; f++) begin
      frame_step("t5", (f < 20) ? 16'h0002 : 16'h0005, 4'h1);
      if (bus.blinkActive[0]) begin
        if (f < 20) cnt++;
        else cnt2++;
      end
    end
    chk("t5_first_part", cnt, 20);
    chk("t5_after_retrigger", cnt2, BF);
    // two layers change together, nothing drawn
    step("t6rst", 1'b0, 1'b0, 4'h0, RGB, 16'h0);
    frame_step("t6arm", 16'h0000, 4'h0);
    frame_step("t6chg", 16'h5050, 4'h0);
    chk("t6_blink_both", 32'(bus.blinkActive), 32'hA);
    chk("t6_nodraw", 32'(bus.drawIndications), 32'd0);
    chk("t6_norgb", 32'(bus.RGBIndications), 32'd0);
    for (int f = 1; f <= 4; f++) frame_step("t6", 16'h5050, 4'hA);
    chk("t6_phase_draw", 32'(bus.drawIndications), 32'(HL));
    chk("t6_phase_rgb", 32'(bus.RGBIndications), HL ? 32'hE0 : 32'h00);
    // random traffic
    step("rrst", 1'b0, 1'b0, 4'h0, RGB, 16'h0);
    cur_v = '0;
    for (int c = 0; c < 1500; c++) begin
      logic s;
      s = ($urandom_range(0, 3) == 0);
      if (s && $urandom_range(0, 3) == 0) cur_v[VW*$urandom_range(0, NL-1) +: VW] = VW'($urandom);
      step("rand", ($urandom_range(0, 499) != 0), s, NL'($urandom), {$urandom}, cur_v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
